// File: rtl/tdisplay_pkg.sv
// Shared definitions for the temperature-to-display converter.
// Holds the FSM state type, the fixed-point scaling constants and a helper
// that yields the largest value representable in a given number of digits.
package tdisplay_pkg;

  typedef enum logic [1:0] {IDLE, CALC, SHIFT, DONE} tdisp_state_t;

  localparam int FRAC_BITS  = 4;
  localparam int SCALE_C    = 10;
  localparam int SCALE_F    = 18;
  localparam int F_OFFSET   = 5120;
  localparam int ROUND_HALF = 8;

  // 10^nd - 1
  function automatic logic [63:0] max_digits(input int unsigned nd);
    logic [63:0] v;
    v = 64'd1;
    for (int unsigned i = 0; i < nd; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

endpackage

// File: rtl/dabble_step.sv
// One double-dabble iteration: every BCD nibble >= 5 gets +3, then the
// accumulator shifts left by one with bit_i entering at the bottom.
// Ports:
//   bcd_i  current BCD accumulator (ND nibbles)
//   bit_i  next binary bit, MSB first
//   bcd_o  corrected and shifted accumulator; the carry out of the top
//          nibble is discarded
module dabble_step #(
  parameter int ND = 4
) (
  input  logic [4*ND-1:0] bcd_i,
  input  logic            bit_i,
  output logic [4*ND-1:0] bcd_o
);

  logic [4*ND-1:0] adj;

  always_comb begin
    adj = bcd_i;
    for (int unsigned i = 0; i < ND; i++) begin
      if (bcd_i[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
    end
    bcd_o = (4*ND)'({adj, bit_i});
  end

endmodule

// File: rtl/tdisplay_seq.sv
// Sequential temperature-to-display converter.
// Accepts a signed 1/16 degC reading plus a C/F select, scales it to rounded
// tenths of a degree, and converts to ND BCD digits one bit per cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tc, c_f, start  request (temperature, 1 = Fahrenheit), taken when ready
//   ready           high only while idle
//   dout_valid      result valid, held until dout_ready
//   bcd, sign, ovf  BCD digits (MSD in top nibble), negative flag, overflow
module tdisplay_seq
  import tdisplay_pkg::*;
#(
  parameter int TW = 13,
  parameter int ND = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TW-1:0]   tc,
  input  logic            c_f,
  input  logic            start,
  output logic            ready,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [4*ND-1:0] bcd,
  output logic            sign,
  output logic            ovf
);

  localparam int PW = TW + 5;
  localparam int RW = TW + 1;
  localparam int CW = $clog2(RW);
  localparam logic [63:0] MAXV = max_digits(ND);

  tdisp_state_t           state_q;
  logic signed [TW-1:0]   tc_q;
  logic                   cf_q;
  logic [CW-1:0]          cnt_q;
  logic [RW-1:0]          sh_q;
  logic [4*ND-1:0]        acc_q, acc_d;
  logic [4*ND-1:0]        bcd_q;
  logic                   ready_q, dv_q, sign_q, ovf_q;

  logic signed [PW-1:0]   tc_ext, x_d;
  logic [PW-1:0]          mag_d;
  logic [RW-1:0]          r_d;
  logic                   sign_d, ovf_d;

  // Scaling, magnitude and half-up rounding, consumed in CALC
  always_comb begin
    tc_ext = PW'(tc_q);
    if (cf_q) x_d = tc_ext * PW'(SCALE_F) + PW'(F_OFFSET);
    else      x_d = tc_ext * PW'(SCALE_C);
    mag_d  = x_d[PW-1] ? PW'(-x_d) : PW'(x_d);
    r_d    = RW'((mag_d + PW'(ROUND_HALF)) >> FRAC_BITS);
    // a value that rounds to zero is always shown as positive
    sign_d = x_d[PW-1] && (r_d != '0);
    ovf_d  = 64'(r_d) > MAXV;
  end

  dabble_step #(.ND(ND)) u_step (
    .bcd_i (acc_q),
    .bit_i (sh_q[RW-1]),
    .bcd_o (acc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      dv_q    <= 1'b0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      tc_q    <= '0;
      cf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            tc_q    <= tc;
            cf_q    <= c_f;
            ready_q <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          sign_q  <= sign_d;
          ovf_q   <= ovf_d;
          sh_q    <= r_d;
          acc_q   <= '0;
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          acc_q <= acc_d;
          sh_q  <= {sh_q[RW-2:0], 1'b0};
          if (cnt_q == CW'(RW - 1)) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // first DONE cycle latches the presented result; handshake after
          if (!dv_q) begin
            bcd_q <= ovf_q ? {ND{4'h9}} : acc_q;
            dv_q  <= 1'b1;
          end else if (dout_ready) begin
            dv_q    <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready      = ready_q;
  assign dout_valid = dv_q;
  assign bcd        = bcd_q;
  assign sign       = sign_q;
  assign ovf        = ovf_q;

endmodule
